// File: rtl/mux_rr_arbiter.sv
// mux_rr_arbiter
// Round-robin arbiter in front of a 4:1 word mux, with one registered output
// stage and a valid/ready handshake. Rotating priority starts just after the
// last winner. An optional lock re-grants the held winner while it still
// requests.
//
// Ports
//   clk        in   clock, rising edge
//   rst        in   synchronous active-high reset
//   req[3:0]   in   request lines (a=0, b=1, c=2, d=3)
//   a,b,c,d    in   requester words, WIDTH bits each
//   lock       in   keep the previous winner if it is still requesting
//   out_ready  in   downstream accepts out when out_valid is also high
//   gnt[3:0]   out  combinational one-hot grant; word consumed on this edge
//   sel[1:0]   out  registered index of the word held in out
//   out        out  registered selected word
//   out_valid  out  out holds an unconsumed word
module mux_rr_arbiter #(
   parameter int unsigned WIDTH = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [3:0]       req,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic [WIDTH-1:0] c,
   input  logic [WIDTH-1:0] d,
   input  logic             lock,
   input  logic             out_ready,
   output logic [3:0]       gnt,
   output logic [1:0]       sel,
   output logic [WIDTH-1:0] out,
   output logic             out_valid
);

   localparam int unsigned NREQ = 4;
   localparam int unsigned IDXW = 2;

   // Rotating-priority pointer and "a winner has been recorded" flag
   logic [IDXW-1:0]  ptr;
   logic             has_win;

   // Next-state values
   logic [IDXW-1:0]  ptr_nxt;
   logic             has_win_nxt;
   logic [IDXW-1:0]  sel_nxt;
   logic [WIDTH-1:0] out_nxt;
   logic             out_valid_nxt;

   // Arbitration intermediates
   logic             slot_open;
   logic             capture;
   logic             lock_hit;
   logic [IDXW-1:0]  rr_win;
   logic [IDXW-1:0]  winner;
   logic [WIDTH-1:0] win_word;

   // Capture slot: empty stage, or full stage being drained this cycle
   assign slot_open = !out_valid || out_ready;
   assign capture   = !rst && slot_open && (req != '0);

   // Lock only applies once a winner exists and it is still requesting
   assign lock_hit  = lock && has_win && req[sel];

   // First requester at or after ptr, wrapping modulo 4
   always_comb begin
      logic [IDXW-1:0] idx;
      logic            found;
      rr_win = ptr;
      idx    = ptr;
      found  = 1'b0;
      for (int unsigned k = 0; k < NREQ; k++) begin
         idx = ptr + IDXW'(k);
         if (!found && req[idx]) begin
            rr_win = idx;
            found  = 1'b1;
         end
      end
   end

   assign winner = lock_hit ? sel : rr_win;

   // Datapath 4:1 mux driven by the winner index
   always_comb begin
      win_word = a;
      case (winner)
         2'd0:    win_word = a;
         2'd1:    win_word = b;
         2'd2:    win_word = c;
         default: win_word = d;
      endcase
   end

   // Grant and next-state decode
   always_comb begin
      gnt           = '0;
      ptr_nxt       = ptr;
      has_win_nxt   = has_win;
      sel_nxt       = sel;
      out_nxt       = out;
      out_valid_nxt = out_valid;

      if (capture) begin
         gnt           = 4'(1) << winner;
         out_nxt       = win_word;
         sel_nxt       = winner;
         out_valid_nxt = 1'b1;
         has_win_nxt   = 1'b1;
         // Priority rotates past the winner even when locked
         ptr_nxt       = winner + IDXW'(1);
      end else if (out_valid && out_ready) begin
         // Drained with nothing to replace it
         out_valid_nxt = 1'b0;
      end
   end

   // State register
   always_ff @(posedge clk) begin
      if (rst) begin
         ptr       <= '0;
         has_win   <= 1'b0;
         sel       <= '0;
         out       <= '0;
         out_valid <= 1'b0;
      end else begin
         ptr       <= ptr_nxt;
         has_win   <= has_win_nxt;
         sel       <= sel_nxt;
         out       <= out_nxt;
         out_valid <= out_valid_nxt;
      end
   end

endmodule

// File: tb/tb_mux_rr_arbiter.sv
// Self-checking bench for mux_rr_arbiter: directed scenarios followed by
// randomized traffic, all compared against a behavioural model.
module tb_mux_rr_arbiter;

   localparam int unsigned WIDTH = 4;

   logic             clk;
   logic             rst;
   logic [3:0]       req;
   logic [WIDTH-1:0] a, b, c, d;
   logic             lock;
   logic             out_ready;
   logic [3:0]       gnt;
   logic [1:0]       sel;
   logic [WIDTH-1:0] out;
   logic             out_valid;

   int n_checks = 0;
   int n_errors = 0;

   // Reference model state
   bit               m_valid;
   logic [WIDTH-1:0] m_out;
   int               m_sel;
   int               m_ptr;
   bit               m_has;

   mux_rr_arbiter #(.WIDTH(WIDTH)) dut (
      .clk       (clk),
      .rst       (rst),
      .req       (req),
      .a         (a),
      .b         (b),
      .c         (c),
      .d         (d),
      .lock      (lock),
      .out_ready (out_ready),
      .gnt       (gnt),
      .sel       (sel),
      .out       (out),
      .out_valid (out_valid)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic logic [WIDTH-1:0] word_of(input int i);
      case (i)
         0:       return a;
         1:       return b;
         2:       return c;
         default: return d;
      endcase
   endfunction

   // Winner index from the model's rules, -1 when nothing is captured
   function automatic int model_winner();
      int w;
      w = -1;
      if (rst) return -1;
      if (m_valid && !out_ready) return -1;
      if (req == 4'b0) return -1;
      if (lock && m_has && req[m_sel]) return m_sel;
      for (int k = 0; k < 4; k++)
         if (w < 0 && req[(m_ptr + k) % 4]) w = (m_ptr + k) % 4;
      return w;
   endfunction

   // One cycle: check outputs before the edge, advance the model on the edge
   task automatic step();
      int w;
      logic [3:0] eg;
      #1;
      w  = model_winner();
      eg = (w < 0) ? 4'b0 : 4'(1 << w);
      check("gnt", 32'(gnt), 32'(eg));
      check("out_valid", 32'(out_valid), 32'(m_valid));
      check("sel", 32'(sel), 32'(m_sel));
      check("out", 32'(out), 32'(m_out));
      @(posedge clk);
      if (rst) begin
         m_valid = 0; m_out = '0; m_sel = 0; m_ptr = 0; m_has = 0;
      end else if (w >= 0) begin
         m_out   = word_of(w);
         m_sel   = w;
         m_valid = 1;
         m_has   = 1;
         m_ptr   = (w + 1) % 4;
      end else if (m_valid && out_ready) begin
         m_valid = 0;
      end
      @(negedge clk);
   endtask

   initial begin
      rst = 1'b1; req = 4'b1111; lock = 1'b0; out_ready = 1'b1;
      a = 4'd1; b = 4'd2; c = 4'd3; d = 4'd4;
      m_valid = 0; m_out = '0; m_sel = 0; m_ptr = 0; m_has = 0;
      @(negedge clk);

      // Reset holds everything idle
      step();
      #1;
      check("rst_gnt", 32'(gnt), 32'h0);
      check("rst_valid", 32'(out_valid), 32'h0);
      check("rst_out", 32'(out), 32'h0);
      check("rst_sel", 32'(sel), 32'h0);
      step();
      rst = 1'b0;
      #1;
      check("first_gnt", 32'(gnt), 32'h1);

      // Full rotation with no bubbles
      for (int i = 0; i < 5; i++) begin
         step();
         check("rot_sel", 32'(sel), 32'(i % 4));
         check("rot_out", 32'(out), 32'(i % 4 + 1));
         check("rot_valid", 32'(out_valid), 32'h1);
      end

      // Sparse request with pointer wrap
      req = 4'b0100;
      step();
      req = 4'b0011;
      #1;
      check("wrap_gnt_a", 32'(gnt), 32'h1);
      step();
      #1;
      check("wrap_gnt_b", 32'(gnt), 32'h2);
      step();

      // Backpressure holds the word and blocks grants
      a = 4'hA; req = 4'b0001;
      step();
      out_ready = 1'b0; req = 4'b0100; c = 4'h5;
      for (int i = 0; i < 5; i++) begin
         #1;
         check("bp_gnt", 32'(gnt), 32'h0);
         check("bp_out", 32'(out), 32'hA);
         step();
      end
      out_ready = 1'b1;
      #1;
      check("bp_release_gnt", 32'(gnt), 32'h4);
      step();
      check("bp_release_out", 32'(out), 32'h5);

      // Lock keeps b until it drops its request
      req = 4'b0010;
      step();
      lock = 1'b1; req = 4'b1111;
      for (int i = 0; i < 3; i++) begin
         step();
         check("lock_sel", 32'(sel), 32'h1);
      end
      req = 4'b1101;
      step();
      check("unlock_sel", 32'(sel), 32'h2);
      lock = 1'b0;

      // Mid-transfer reset discards the held word and restarts priority
      rst = 1'b1; req = 4'b0000;
      step();
      check("midrst_valid", 32'(out_valid), 32'h0);
      rst = 1'b0; req = 4'b1100;
      #1;
      check("midrst_gnt", 32'(gnt), 32'h4);
      step();

      // Randomized traffic
      for (int i = 0; i < 2000; i++) begin
         req       = 4'($urandom);
         lock      = ($urandom % 4) == 0;
         out_ready = ($urandom % 4) != 0;
         rst       = ($urandom % 64) == 0;
         a = WIDTH'($urandom); b = WIDTH'($urandom);
         c = WIDTH'($urandom); d = WIDTH'($urandom);
         step();
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/mux_rr_arbiter.md
# mux_rr_arbiter

Round-robin arbiter and sequencer in front of the 4:1 multiplexer datapath. Four requesters each present a `WIDTH`-bit word with a request line. The block picks one winner per transfer, drives the mux select and a one-hot grant, and registers the selected word into a single output stage with a valid/ready handshake. Fairness is rotating priority, with an optional lock that keeps the current winner.

## Interface
- `WIDTH`, default 4: data width of each requester word and of `out`.
- `clk` in 1: clock; all state updates on the rising edge.
- `rst` in 1: synchronous, active-high reset.
- `req` in 4: request lines; bit i requests from input i (a=0, b=1, c=2, d=3).
- `a`, `b`, `c`, `d` in WIDTH each: requester data words.
- `lock` in 1: when high, re-grant the previous winner if it still requests.
- `out_ready` in 1: downstream accepts `out` when high together with `out_valid`.
- `gnt` out 4: combinational one-hot grant; requester i's word is consumed on the edge where `gnt[i]`=1.
- `sel` out 2: registered index of the word currently held in `out`.
- `out` out WIDTH: registered selected word.
- `out_valid` out 1: `out` holds an unconsumed word.

## Operation
- State: output register (FULL when `out_valid`=1, EMPTY otherwise), 2-bit pointer `ptr`, and a `has_win` flag.
- Reset values: `out_valid`=0, `out`=0, `sel`=0, `ptr`=0, `has_win`=0. `gnt`=0 while `rst`=1.
- The capture slot is open when EMPTY, or when FULL and `out_ready`=1.
- Winner selection, only when the slot is open and `req`≠0:
  - If `lock`=1, `has_win`=1 and `req[sel]`=1, the winner is `sel`.
  - Otherwise the winner is the first set bit of `req`, scanning `ptr`, `ptr`+1, `ptr`+2, `ptr`+3 mod 4.
- On a capture edge:
  - `out` ← word[winner], `sel` ← winner, `out_valid` ← 1, `has_win` ← 1.
  - `ptr` ← winner+1 mod 4 (3 wraps to 0). This also applies under lock.
- Slot open with `req`=0: `gnt`=0. If FULL and `out_ready`=1, then `out_valid` ← 0. `sel`, `out` and `ptr` hold.
- Slot closed (FULL, `out_ready`=0): `gnt`=0. `out`, `sel` and `out_valid` stay stable. Requests wait.
- Requesters keep `req` and data stable until granted. Dropping `req` before grant is legal and simply withdraws the request.
- `req` is not sticky inside the block. A requester that keeps `req` high after its grant requests again.

## Timing
- `gnt` is combinational from `req`, `lock`, `out_ready` and state, in the same cycle as the capture edge.
- Latency from req to out: word granted at edge N appears with `out_valid`=1 after edge N, i.e. 1 cycle.
- Throughput: 1 word/cycle while `out_ready`=1. Simultaneous consume and capture replaces `out` with no bubble.
- Backpressure: with `out_ready`=0 and FULL, `gnt` stays 0 indefinitely. No data is lost or overwritten.
- Fairness: with `lock`=0, each continuously requesting input is granted at least once every 4 captures.
- Mid-operation reset: a held word is discarded, `out_valid` is 0 after the reset edge, and priority restarts at input 0.
- No combinational path from `out_ready` to `out`. A path to `gnt` exists.

## Test plan
- Reset: hold `rst`=1 with `req`=4'b1111 → `gnt`=0, `out_valid`=0, `out`=0, `sel`=0. First cycle after release: `gnt`=4'b0001.
- Full rotation: `req`=4'b1111, `out_ready`=1, a=1 b=2 c=3 d=4 → `sel` sequence 0,1,2,3,0 on consecutive cycles, `out` sequence 1,2,3,4,1, `out_valid` continuously 1.
- Sparse plus wrap: `ptr`=3 (after a grant to c), `req`=4'b0011 → `gnt`=4'b0001 (a), then 4'b0010 (b).
- Backpressure: FULL with `out`=0xA, `out_ready`=0 for 5 cycles, `req`=4'b0100 → `gnt`=0, `out`=0xA stable. Raise `out_ready` → that cycle `gnt`=4'b0100, next cycle `out`=c.
- Lock: `lock`=1 after a grant to b, `req`=4'b1111 → `sel`=1 repeatedly. Drop `req[1]` → next grant to c (`ptr`=2).
- Mid-transfer reset: FULL with `sel`=2, assert `rst` one cycle → `out_valid`=0. With `req`=4'b1100, next grant is c (`gnt`=4'b0100).
